// File: rtl/spi_responder.sv
// SPI mode-0 responder bridging an external SPI master to the Z80 I/O bus.
// Byte-wide RX/TX holding registers plus a status/control port.
module spi_responder #(
    parameter logic [7:0] PORT_DATA = 8'hF3,
    parameter logic [7:0] PORT_STAT = 8'hEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cep,
    input  logic       iorq,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    input  logic       spiCs,
    input  logic       spiCk,
    input  logic       spiDi,
    output logic       spiDo
);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;

    logic [1:0] cs_sync_r;
    logic [1:0] ck_sync_r;
    logic [1:0] di_sync_r;
    logic       ck_prev_r;
    logic       data_wr_prev_r;
    logic       data_rd_prev_r;
    logic       stat_wr_prev_r;

    logic [1:0] state_r;
    logic [2:0] bitcnt_r;
    logic [6:0] rxsh_r;
    logic [7:0] txsh_r;
    logic [7:0] rxd_r;
    logic [7:0] txd_r;
    logic       rxf_r;
    logic       txf_r;
    logic       ovr_r;
    logic       skip_fall_r;
    logic       spi_do_r;

    logic       cs_s;
    logic       ck_s;
    logic       di_s;
    logic       ck_rise_s;
    logic       ck_fall_s;
    logic       sel_s;
    logic       data_wr_lvl_s;
    logic       data_rd_lvl_s;
    logic       stat_wr_lvl_s;
    logic       data_wr_s;
    logic       data_rd_s;
    logic       stat_wr_s;
    logic [1:0] state_next_s;
    logic       load_tx_s;
    logic       shift_in_s;
    logic       shift_out_s;
    logic       byte_done_s;
    logic [7:0] tx_load_s;
    logic [7:0] txsh_next_s;
    logic [7:0] status_s;

    assign cs_s      = cs_sync_r[1];
    assign ck_s      = ck_sync_r[1];
    assign di_s      = di_sync_r[1];
    assign ck_rise_s = ck_s & ~ck_prev_r;
    assign ck_fall_s = ~ck_s & ck_prev_r;
    assign sel_s     = ~cs_s & (state_r != ST_DISARMED);
    assign status_s  = {4'b0000, sel_s, ovr_r, txf_r, rxf_r};
    assign tx_load_s = txf_r ? txd_r : 8'hFF;

    assign data_wr_lvl_s = ~iorq & ~wr & (a == PORT_DATA);
    assign data_rd_lvl_s = ~iorq & ~rd & (a == PORT_DATA);
    assign stat_wr_lvl_s = ~iorq & ~wr & (a == PORT_STAT);
    assign data_wr_s     = cep & data_wr_lvl_s & ~data_wr_prev_r;
    assign data_rd_s     = cep & data_rd_lvl_s & ~data_rd_prev_r;
    assign stat_wr_s     = cep & stat_wr_lvl_s & ~stat_wr_prev_r;

    assign q     = (a == PORT_DATA) ? rxd_r : status_s;
    assign spiDo = spi_do_r;

    // Two-flop synchronisers for the asynchronous SPI pins, free-running.
    // CS resets to "selected" so a reset during a transfer waits for a real deselect.
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync_r <= 2'b00;
            ck_sync_r <= 2'b00;
            di_sync_r <= 2'b00;
            ck_prev_r <= 1'b0;
        end else begin
            cs_sync_r <= {cs_sync_r[0], spiCs};
            ck_sync_r <= {ck_sync_r[0], spiCk};
            di_sync_r <= {di_sync_r[0], spiDi};
            ck_prev_r <= ck_s;
        end
    end

    // Bus strobe history, advanced only on CPU clock enables.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_wr_prev_r <= 1'b0;
            data_rd_prev_r <= 1'b0;
            stat_wr_prev_r <= 1'b0;
        end else if (cep) begin
            data_wr_prev_r <= data_wr_lvl_s;
            data_rd_prev_r <= data_rd_lvl_s;
            stat_wr_prev_r <= stat_wr_lvl_s;
        end else begin
            data_wr_prev_r <= data_wr_prev_r;
            data_rd_prev_r <= data_rd_prev_r;
            stat_wr_prev_r <= stat_wr_prev_r;
        end
    end

    // Link state machine and the per-edge shift actions it authorises.
    always_comb begin
        state_next_s = state_r;
        load_tx_s    = 1'b0;
        shift_in_s   = 1'b0;
        shift_out_s  = 1'b0;
        byte_done_s  = 1'b0;
        case (state_r)
            ST_DISARMED: begin
                if (cs_s) state_next_s = ST_IDLE;
                else      state_next_s = ST_DISARMED;
            end
            ST_IDLE: begin
                if (!cs_s) begin
                    state_next_s = ST_ACTIVE;
                    load_tx_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_next_s = ST_IDLE;
                end else if (ck_rise_s) begin
                    shift_in_s = 1'b1;
                    if (bitcnt_r == 3'd7) begin
                        byte_done_s = 1'b1;
                        load_tx_s   = 1'b1;
                    end else begin
                        byte_done_s = 1'b0;
                    end
                end else if (ck_fall_s && !skip_fall_r) begin
                    shift_out_s = 1'b1;
                end else begin
                    shift_out_s = 1'b0;
                end
            end
            default: state_next_s = ST_DISARMED;
        endcase
    end

    // Next transmit shifter value: a fresh load beats a shift.
    always_comb begin
        txsh_next_s = txsh_r;
        if (load_tx_s)        txsh_next_s = tx_load_s;
        else if (shift_out_s) txsh_next_s = {txsh_r[6:0], 1'b1};
        else                  txsh_next_s = txsh_r;
    end

    // Shift path: state, bit counter, shifters and the MISO register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_DISARMED;
            bitcnt_r    <= 3'd0;
            rxsh_r      <= 7'd0;
            txsh_r      <= 8'hFF;
            skip_fall_r <= 1'b0;
            spi_do_r    <= 1'b1;
        end else begin
            state_r  <= state_next_s;
            txsh_r   <= txsh_next_s;
            spi_do_r <= (state_next_s == ST_ACTIVE) ? txsh_next_s[7] : 1'b1;
            if (state_r != ST_ACTIVE) bitcnt_r <= 3'd0;
            else if (shift_in_s)      bitcnt_r <= bitcnt_r + 3'd1;
            else                      bitcnt_r <= bitcnt_r;
            if (shift_in_s) rxsh_r <= {rxsh_r[5:0], di_s};
            else            rxsh_r <= rxsh_r;
            // The fall right after a byte-boundary load must not eat the new MSB.
            if (byte_done_s)                            skip_fall_r <= 1'b1;
            else if (ck_fall_s || state_r != ST_ACTIVE) skip_fall_r <= 1'b0;
            else                                        skip_fall_r <= skip_fall_r;
        end
    end

    // CPU-visible holding registers and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_r <= 8'h00;
            txd_r <= 8'hFF;
            rxf_r <= 1'b0;
            txf_r <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            if (byte_done_s) begin
                rxd_r <= {rxsh_r, di_s};
                rxf_r <= 1'b1;
            end else if (data_rd_s) begin
                rxf_r <= 1'b0;
            end else begin
                rxf_r <= rxf_r;
            end
            if (byte_done_s && rxf_r && !data_rd_s) ovr_r <= 1'b1;
            else if (stat_wr_s && d[2])             ovr_r <= 1'b0;
            else                                    ovr_r <= ovr_r;
            if (data_wr_s) begin
                txd_r <= d;
                txf_r <= 1'b1;
            end else if (load_tx_s || (stat_wr_s && d[1])) begin
                txf_r <= 1'b0;
            end else begin
                txf_r <= txf_r;
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed scenarios followed by random frames,
// all checked against a byte-level model of the holding registers.
module tb_spi_responder;

    localparam logic [7:0] PORT_DATA = 8'hF3;
    localparam logic [7:0] PORT_STAT = 8'hEF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cep   = 1'b1;
    logic       iorq  = 1'b1;
    logic       wr    = 1'b1;
    logic       rd    = 1'b1;
    logic [7:0] a     = 8'h00;
    logic [7:0] d     = 8'h00;
    logic [7:0] q;
    logic       spiCs = 1'b1;
    logic       spiCk = 1'b0;
    logic       spiDi = 1'b0;
    logic       spiDo;

    int compared   = 0;
    int mismatched = 0;
    int half       = 4;

    logic [7:0] m_rxd;
    logic [7:0] m_txd;
    logic       m_rxf;
    logic       m_txf;
    logic       m_ovr;

    spi_responder dut (
        .clock(clock), .reset(reset), .cep(cep), .iorq(iorq), .wr(wr), .rd(rd),
        .a(a), .d(d), .q(q),
        .spiCs(spiCs), .spiCk(spiCk), .spiDi(spiDi), .spiDo(spiDo)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Behavioural model: byte-level holding registers.
    task automatic m_reset();
        m_rxd = 8'h00; m_txd = 8'hFF; m_rxf = 1'b0; m_txf = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic m_load(output logic [7:0] v);
        v = m_txf ? m_txd : 8'hFF;
        m_txf = 1'b0;
    endtask

    task automatic m_complete(input logic [7:0] b, input logic popped);
        if (m_rxf && !popped) m_ovr = 1'b1;
        m_rxd = b;
        m_rxf = 1'b1;
    endtask

    function automatic logic [7:0] m_status(input logic sel);
        return {4'b0000, sel, m_ovr, m_txf, m_rxf};
    endfunction

    task automatic peek(input logic [7:0] addr, output logic [7:0] v);
        a = addr;
        #1;
        v = q;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        a = addr; d = data; iorq = 1'b0; wr = 1'b0;
        tick(2);
        iorq = 1'b1; wr = 1'b1;
        tick(1);
        if (addr == PORT_DATA) begin
            m_txd = data; m_txf = 1'b1;
        end else begin
            if (data[2]) m_ovr = 1'b0;
            if (data[1]) m_txf = 1'b0;
        end
    endtask

    task automatic io_read_data(output logic [7:0] v);
        a = PORT_DATA; iorq = 1'b0; rd = 1'b0;
        #1;
        v = q;
        tick(2);
        iorq = 1'b1; rd = 1'b1;
        tick(1);
        m_rxf = 1'b0;
    endtask

    // Master side: n bits MSB first, MISO sampled just before each SCK rise.
    task automatic spi_bits(input logic [7:0] mosi, input int n, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < n; i++) begin
            spiDi = mosi[7-i];
            tick(half);
            miso[7-i] = spiDo;
            spiCk = 1'b1;
            tick(half);
            spiCk = 1'b0;
        end
    endtask

    task automatic cs_low(output logic [7:0] exp_tx);
        spiCs = 1'b0;
        tick(6);
        m_load(exp_tx);
    endtask

    task automatic cs_high();
        spiCs = 1'b1;
        tick(6);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] w;
        logic [7:0] got;
        logic [7:0] exp_tx;
        logic [7:0] mask;
        int         nb;
        int         nbits;

        m_reset();
        tick(4);
        reset = 1'b0;
        tick(4);

        // Reset state.
        peek(PORT_DATA, v); check8("rst_rxd", v, 8'h00);
        peek(PORT_STAT, v); check8("rst_stat", v, 8'h00);
        check8("rst_spido", {7'd0, spiDo}, 8'h01);

        // 1: receive A5, pop it, MISO idles at FF.
        cs_low(exp_tx);
        spi_bits(8'hA5, 8, got);
        check8("t1_miso", got, exp_tx);
        m_complete(8'hA5, 1'b0);
        m_load(exp_tx);
        cs_high();
        peek(PORT_DATA, v); check8("t1_rxd", v, 8'hA5);
        peek(PORT_STAT, v); check8("t1_stat", v, m_status(1'b0));
        io_read_data(v);    check8("t1_pop", v, 8'hA5);
        peek(PORT_STAT, v); check8("t1_stat_pop", v, m_status(1'b0));

        // 2: transmit 3C; txf drops at CS fall.
        io_write(PORT_DATA, 8'h3C);
        peek(PORT_STAT, v); check8("t2_txf", v, m_status(1'b0));
        cs_low(exp_tx);
        peek(PORT_STAT, v); check8("t2_stat_sel", v, m_status(1'b1));
        spi_bits(8'h00, 8, got);
        check8("t2_miso", got, 8'h3C);
        m_complete(8'h00, 1'b0);
        m_load(exp_tx);
        cs_high();
        io_read_data(v);

        // 3: two bytes without a pop -> overrun, then clear it.
        cs_low(exp_tx);
        spi_bits(8'h11, 8, got); m_complete(8'h11, 1'b0); m_load(exp_tx);
        spi_bits(8'h22, 8, got); m_complete(8'h22, 1'b0); m_load(exp_tx);
        cs_high();
        peek(PORT_DATA, v); check8("t3_rxd", v, 8'h22);
        peek(PORT_STAT, v); check8("t3_stat", v, 8'h05);
        io_write(PORT_STAT, 8'h04);
        peek(PORT_STAT, v); check8("t3_clr_ovr", v, 8'h01);
        io_read_data(v);

        // 4: partial byte discarded, then a full 7E.
        cs_low(exp_tx);
        spi_bits(8'hFF, 5, got);
        cs_high();
        peek(PORT_STAT, v); check8("t4_partial", v, m_status(1'b0));
        cs_low(exp_tx);
        spi_bits(8'h7E, 8, got); m_complete(8'h7E, 1'b0); m_load(exp_tx);
        cs_high();
        peek(PORT_DATA, v); check8("t4_rxd", v, 8'h7E);
        io_read_data(v);

        // 5: reset mid-byte with CS held low: nothing decoded, MISO stays high.
        cs_low(exp_tx);
        spi_bits(8'hC3, 4, got);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_reset();
        spi_bits(8'h96, 8, got);
        check8("t5_miso", got, 8'hFF);
        check8("t5_spido", {7'd0, spiDo}, 8'h01);
        peek(PORT_STAT, v); check8("t5_stat", v, 8'h00);
        peek(PORT_DATA, v); check8("t5_rxd", v, 8'h00);
        cs_high();

        // 6: DATA read lands on the same clock as the 8th-bit completion.
        cs_low(exp_tx);
        spi_bits(8'h5A, 8, got); m_complete(8'h5A, 1'b0); m_load(exp_tx);
        spi_bits(8'hC6, 7, got);
        spiDi = 1'b0;
        tick(half);
        spiCk = 1'b1;
        tick(2);
        a = PORT_DATA; iorq = 1'b0; rd = 1'b0;
        tick(2);
        iorq = 1'b1; rd = 1'b1;
        spiCk = 1'b0;
        m_complete(8'hC6, 1'b1);
        m_load(exp_tx);
        cs_high();
        peek(PORT_DATA, v); check8("t6_rxd", v, 8'hC6);
        peek(PORT_STAT, v); check8("t6_stat", v, 8'h01);

        // Random frames against the model.
        for (int it = 0; it < 24; it++) begin
            half = $urandom_range(3, 6);
            if ($urandom_range(0, 1) == 1) io_write(PORT_DATA, 8'($urandom));
            cs_low(exp_tx);
            peek(PORT_STAT, v); check8("rnd_sel", v, m_status(1'b1));
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                w = 8'($urandom);
                spi_bits(w, 8, got);
                check8("rnd_miso", got, exp_tx);
                m_complete(w, 1'b0);
                m_load(exp_tx);
                if ($urandom_range(0, 3) == 0) io_write(PORT_DATA, 8'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                nbits = $urandom_range(1, 7);
                mask  = 8'hFF << (8 - nbits);
                spi_bits(8'($urandom), nbits, got);
                check8("rnd_partial_miso", got, exp_tx & mask);
            end
            cs_high();
            check8("rnd_spido", {7'd0, spiDo}, 8'h01);
            peek(PORT_STAT, v); check8("rnd_stat", v, m_status(1'b0));
            peek(PORT_DATA, v); check8("rnd_rxd", v, m_rxd);
            if ($urandom_range(0, 1) == 1) begin
                w = m_rxd;
                io_read_data(v);
                check8("rnd_pop", v, w);
            end
            if ($urandom_range(0, 2) == 0) begin
                io_write(PORT_STAT, 8'($urandom));
                peek(PORT_STAT, v); check8("rnd_ctrl", v, m_status(1'b0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
